vxu_lane_fu_seq: RTL and testbench

- Parametrised per-lane functional-unit sequencer for the banked vector lane.
- Accepts issue commands from the lane expander, one per FU channel (VAU0/1/2, VGU, VLU, VSU, …).
- Produces per-channel valid/fn strobes for exactly N elements, where N is the element count carried by the command.
- Over the previous fixed-six-unit sequencer, it adds: a configurable channel count, a per-channel stall input that freezes the countdown, a one-entry pending slot per channel for back-to-back issue, a last-element flag, and per-channel same-cycle bypass.

---
 rtl/vxu_lane_fu_seq.sv | 147 ++++++++++++++
 tb/tb_vxu_lane_fu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vxu_lane_fu_seq.sv
`default_nettype none
// ============================================================================
// Module   : vxu_lane_fu_seq
// Purpose  : Per-lane functional-unit sequencer. Each FU channel accepts an
//            issue command (element count minus one + function code) and
//            emits one valid/fn strobe per element until the count is
//            exhausted. Each channel has a one-entry pending slot for
//            back-to-back issue, honours a per-channel stall, flags the last
//            element, and can optionally start in the issue cycle (bypass).
// Ports    : clk_i          clock
//            reset_i        asynchronous active-high reset
//            issue_val_i    per-channel issue request
//            issue_rdy_o    per-channel issue ready (pending slot empty)
//            issue_cnt_i    element count minus one (shared)
//            issue_fn_i     per-channel function code, channel i at [i*FN_W +: FN_W]
//            fu_stall_i     per-channel FU stall; holds the current element
//            fu_val_o       per-channel element valid
//            fu_fn_o        per-channel function code with fu_val_o
//            fu_last_o      current valid element is the last of its command
//            fu_busy_o      channel holds an active or pending command
// Revision : 1.0 - initial release
// ============================================================================
module vxu_lane_fu_seq #(
  parameter int                NUM_FU      = 6,
  parameter int                CNT_W       = 8,
  parameter int                FN_W        = 11,
  parameter logic [NUM_FU-1:0] BYPASS_MASK = NUM_FU'(6'b010000)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_FU-1:0]      issue_val_i,
  output logic [NUM_FU-1:0]      issue_rdy_o,
  input  logic [CNT_W-1:0]       issue_cnt_i,
  input  logic [NUM_FU*FN_W-1:0] issue_fn_i,
  input  logic [NUM_FU-1:0]      fu_stall_i,
  output logic [NUM_FU-1:0]      fu_val_o,
  output logic [NUM_FU*FN_W-1:0] fu_fn_o,
  output logic [NUM_FU-1:0]      fu_last_o,
  output logic [NUM_FU-1:0]      fu_busy_o
);

  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_ch
    logic             act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FN_W-1:0]  fn_q,  fn_d;
    logic             pv_q,  pv_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [FN_W-1:0]  pfn_q,  pfn_d;

    logic             w_acc;
    logic             w_byp;
    logic             w_val;
    logic             w_fire;
    logic             w_finish;
    logic [CNT_W-1:0] w_cnt_eff;
    logic [FN_W-1:0]  w_issue_fn;

    assign w_issue_fn = issue_fn_i[gi*FN_W +: FN_W];

    // Accepts are masked while reset is held so a bypass channel cannot
    // present a same-cycle element during reset.
    assign w_acc = issue_val_i[gi] & ~pv_q & ~reset_i;

    // Same-cycle bypass start: only from a fully idle bypass channel.
    assign w_byp = BYPASS_MASK[gi] & w_acc & ~act_q;

    assign w_val     = act_q | w_byp;
    assign w_cnt_eff = act_q ? cnt_q : issue_cnt_i;
    assign w_fire    = w_val & ~fu_stall_i[gi];
    assign w_finish  = act_q & w_fire & (cnt_q == C_CNT_ZERO);

    assign issue_rdy_o[gi]             = ~pv_q;
    assign fu_val_o[gi]                = w_val;
    assign fu_fn_o[gi*FN_W +: FN_W]    = w_byp ? w_issue_fn : fn_q;
    assign fu_last_o[gi]               = w_val & (w_cnt_eff == C_CNT_ZERO);
    assign fu_busy_o[gi]               = act_q | pv_q;

    always_comb begin
      act_d  = act_q;
      cnt_d  = cnt_q;
      fn_d   = fn_q;
      pv_d   = pv_q;
      pcnt_d = pcnt_q;
      pfn_d  = pfn_q;

      if (act_q) begin
        if (w_fire && (cnt_q != C_CNT_ZERO)) begin
          cnt_d = cnt_q - C_CNT_ONE;
        end

        if (w_finish) begin
          // Hand over with no bubble: pending slot first, otherwise a
          // same-cycle accept goes straight into the active slot.
          if (pv_q) begin
            cnt_d = pcnt_q;
            fn_d  = pfn_q;
            pv_d  = 1'b0;
          end else if (w_acc) begin
            cnt_d = issue_cnt_i;
            fn_d  = w_issue_fn;
          end else begin
            act_d = 1'b0;
          end
        end else if (w_acc) begin
          pv_d   = 1'b1;
          pcnt_d = issue_cnt_i;
          pfn_d  = w_issue_fn;
        end
      end else if (w_acc) begin
        fn_d = w_issue_fn;
        if (w_byp && w_fire) begin
          // First element already consumed in the issue cycle.
          if (issue_cnt_i != C_CNT_ZERO) begin
            act_d = 1'b1;
            cnt_d = issue_cnt_i - C_CNT_ONE;
          end
        end else begin
          act_d = 1'b1;
          cnt_d = issue_cnt_i;
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        act_q  <= 1'b0;
        cnt_q  <= '0;
        fn_q   <= '0;
        pv_q   <= 1'b0;
        pcnt_q <= '0;
        pfn_q  <= '0;
      end else begin
        act_q  <= act_d;
        cnt_q  <= cnt_d;
        fn_q   <= fn_d;
        pv_q   <= pv_d;
        pcnt_q <= pcnt_d;
        pfn_q  <= pfn_d;
      end
    end
  end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_vxu_lane_fu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vxu_lane_fu_seq
// Purpose  : Directed self-checking bench for vxu_lane_fu_seq. Inputs change
//            1 time unit after the rising edge; outputs are sampled 4 units
//            after the rising edge (before the falling edge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vxu_lane_fu_seq;

  localparam int C_NUM_FU = 6;
  localparam int C_CNT_W  = 8;
  localparam int C_FN_W   = 11;

  logic                       clk;
  logic                       reset;
  logic [C_NUM_FU-1:0]        issue_val;
  logic [C_NUM_FU-1:0]        issue_rdy;
  logic [C_CNT_W-1:0]         issue_cnt;
  logic [C_NUM_FU*C_FN_W-1:0] issue_fn;
  logic [C_NUM_FU-1:0]        fu_stall;
  logic [C_NUM_FU-1:0]        fu_val;
  logic [C_NUM_FU*C_FN_W-1:0] fu_fn;
  logic [C_NUM_FU-1:0]        fu_last;
  logic [C_NUM_FU-1:0]        fu_busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_fires;

  vxu_lane_fu_seq #(
    .NUM_FU      (C_NUM_FU),
    .CNT_W       (C_CNT_W),
    .FN_W        (C_FN_W),
    .BYPASS_MASK (6'b010000)
  ) u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .issue_val_i (issue_val),
    .issue_rdy_o (issue_rdy),
    .issue_cnt_i (issue_cnt),
    .issue_fn_i  (issue_fn),
    .fu_stall_i  (fu_stall),
    .fu_val_o    (fu_val),
    .fu_fn_o     (fu_fn),
    .fu_last_o   (fu_last),
    .fu_busy_o   (fu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    #3;
  endtask

  task automatic set_fn(input int ch, input logic [C_FN_W-1:0] v);
    issue_fn[ch*C_FN_W +: C_FN_W] = v;
  endtask

  function automatic logic [31:0] fn_of(input int ch);
    return 32'(fu_fn[ch*C_FN_W +: C_FN_W]);
  endfunction

  initial begin
    reset     = 1'b1;
    issue_val = '0;
    issue_cnt = '0;
    issue_fn  = '0;
    fu_stall  = '0;
    #2;
    chk("rst_val",  32'(fu_val),    32'h0);
    chk("rst_last", 32'(fu_last),   32'h0);
    chk("rst_busy", 32'(fu_busy),   32'h0);
    chk("rst_rdy",  32'(issue_rdy), 32'h3f);
    chk("rst_fn",   32'(fu_fn[31:0]), 32'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // ---- Registered channel 0, cnt=3 ----
    issue_val[0] = 1'b1; issue_cnt = 8'd3; set_fn(0, 11'h011);
    samp();
    chk("t1_c0_val",  32'(fu_val[0]),  32'h0);
    chk("t1_c0_busy", 32'(fu_busy[0]), 32'h0);
    tick();
    issue_val = '0;
    for (int c = 1; c <= 5; c++) begin
      samp();
      chk($sformatf("t1_val_c%0d", c),  32'(fu_val[0]),  (c <= 4) ? 32'h1 : 32'h0);
      chk($sformatf("t1_last_c%0d", c), 32'(fu_last[0]), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t1_busy_c%0d", c), 32'(fu_busy[0]), (c <= 4) ? 32'h1 : 32'h0);
      if (c <= 4) chk($sformatf("t1_fn_c%0d", c), fn_of(0), 32'h011);
      tick();
    end

    // ---- Channel 1, cnt=2, stall at cycles 2-3 ----
    issue_val[1] = 1'b1; issue_cnt = 8'd2; set_fn(1, 11'h122);
    tick();
    issue_val = '0;
    n_fires = 0;
    for (int c = 1; c <= 6; c++) begin
      fu_stall[1] = (c == 2 || c == 3);
      samp();
      if (fu_val[1] && !fu_stall[1]) n_fires++;
      chk($sformatf("t2_val_c%0d", c),  32'(fu_val[1]),  (c <= 5) ? 32'h1 : 32'h0);
      chk($sformatf("t2_last_c%0d", c), 32'(fu_last[1]), (c == 5) ? 32'h1 : 32'h0);
      tick();
    end
    fu_stall = '0;
    chk("t2_fires", 32'(n_fires), 32'd3);

    // ---- Back-to-back on channel 2 ----
    issue_val[2] = 1'b1; issue_cnt = 8'd1; set_fn(2, 11'h0a1);
    tick();
    issue_cnt = 8'd0; set_fn(2, 11'h0b2);
    samp();
    chk("t3_rdy_c1", 32'(issue_rdy[2]), 32'h1);
    tick();
    issue_val = '0;
    for (int c = 2; c <= 4; c++) begin
      samp();
      chk($sformatf("t3_val_c%0d", c),  32'(fu_val[2]),  (c <= 3) ? 32'h1 : 32'h0);
      chk($sformatf("t3_last_c%0d", c), 32'(fu_last[2]), (c <= 3) ? 32'h1 : 32'h0);
      if (c == 2) chk("t3_rdy_c2", 32'(issue_rdy[2]), 32'h0);
      if (c == 2) chk("t3_fn_c2", fn_of(2), 32'h0a1);
      if (c == 3) chk("t3_fn_c3", fn_of(2), 32'h0b2);
      if (c == 3) chk("t3_rdy_c3", 32'(issue_rdy[2]), 32'h1);
      tick();
    end

    // ---- Bypass channel 4, cnt=0 ----
    issue_val[4] = 1'b1; issue_cnt = 8'd0; set_fn(4, 11'h3c4);
    samp();
    chk("t4a_val",  32'(fu_val[4]),  32'h1);
    chk("t4a_last", 32'(fu_last[4]), 32'h1);
    chk("t4a_fn",   fn_of(4),        32'h3c4);
    chk("t4a_busy", 32'(fu_busy[4]), 32'h0);
    tick();
    issue_val = '0;
    samp();
    chk("t4a_val_c1",  32'(fu_val[4]),  32'h0);
    chk("t4a_busy_c1", 32'(fu_busy[4]), 32'h0);
    tick();

    // ---- Bypass channel 4, cnt=2 ----
    issue_val[4] = 1'b1; issue_cnt = 8'd2; set_fn(4, 11'h255);
    for (int c = 0; c <= 3; c++) begin
      samp();
      chk($sformatf("t4b_val_c%0d", c),  32'(fu_val[4]),  (c <= 2) ? 32'h1 : 32'h0);
      chk($sformatf("t4b_last_c%0d", c), 32'(fu_last[4]), (c == 2) ? 32'h1 : 32'h0);
      if (c <= 2) chk($sformatf("t4b_fn_c%0d", c), fn_of(4), 32'h255);
      if (c == 1) chk("t4b_busy_c1", 32'(fu_busy[4]), 32'h1);
      tick();
      issue_val = '0;
    end

    // ---- Third issue while pending full on channel 3 ----
    issue_val[3] = 1'b1; issue_cnt = 8'd2; set_fn(3, 11'h0a3);
    tick();
    issue_cnt = 8'd0; set_fn(3, 11'h0b3);
    tick();
    set_fn(3, 11'h0c3);
    samp();
    chk("t5_rdy_c2", 32'(issue_rdy[3]), 32'h0);
    tick();
    issue_val = '0;
    for (int c = 3; c <= 5; c++) begin
      samp();
      chk($sformatf("t5_rdy_c%0d", c), 32'(issue_rdy[3]), (c == 3) ? 32'h0 : 32'h1);
      chk($sformatf("t5_val_c%0d", c), 32'(fu_val[3]),    (c <= 4) ? 32'h1 : 32'h0);
      if (c == 4) chk("t5_fn_c4",   fn_of(3),            32'h0b3);
      if (c == 4) chk("t5_last_c4", 32'(fu_last[3]),     32'h1);
      tick();
    end

    // ---- Reset mid-command with pending valid on channel 0 ----
    issue_val[0] = 1'b1; issue_cnt = 8'd5; set_fn(0, 11'h055);
    tick();
    issue_cnt = 8'd1; set_fn(0, 11'h066);
    tick();
    issue_val = '0;
    samp();
    chk("t6_pre_busy", 32'(fu_busy[0]),   32'h1);
    chk("t6_pre_rdy",  32'(issue_rdy[0]), 32'h0);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_val",  32'(fu_val[0]),  32'h0);
    chk("t6_async_busy", 32'(fu_busy[0]), 32'h0);
    chk("t6_async_last", 32'(fu_last[0]), 32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      samp();
      chk($sformatf("t6_post_rdy_%0d", c),  32'(issue_rdy), 32'h3f);
      chk($sformatf("t6_post_val_%0d", c),  32'(fu_val),    32'h0);
      chk($sformatf("t6_post_busy_%0d", c), 32'(fu_busy),   32'h0);
      chk($sformatf("t6_post_last_%0d", c), 32'(fu_last),   32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
